wb_ascon_arbiter: RTL and testbench
===================================

WB_ASCON_ARBITER -- requirements
Module: wb_ascon_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max granted cycles with stb high and no ack.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port nRST, input, 1, reset (asynchronous, active-low).
REQ-004 SHALL have ports mN_adr_i/mN_dat_i, input, 32 each, master N address/write data (N=0,1).
REQ-005 SHALL have ports mN_sel_i input 4, mN_we_i/mN_cyc_i/mN_stb_i input 1 each, master N Wishbone controls.
REQ-006 SHALL have ports mN_ack_o output 1, mN_err_o output 1 and mN_dat_o output 32, master N responses.
REQ-007 SHALL have ports s_adr_o/s_dat_o output 32, s_sel_o output 4, s_we_o/s_cyc_o/s_stb_o output 1, driving the wb_ASCON slave.
REQ-008 SHALL have ports s_ack_i input 1 and s_dat_i input 32, the slave response.
REQ-009 SHALL have port grant_o, output, 2, one-hot current grant (00 = none).

Function
REQ-010 SHALL implement FSM states IDLE, GNT0 and GNT1.
REQ-011 In IDLE, a single mN_cyc_i high SHALL move the FSM to GNTN on the next clk edge (grant latency 1 cycle).
REQ-012 In IDLE with both cyc high, the grant SHALL go to the master indicated by the round-robin pointer.
REQ-013 The pointer SHALL point to master 0 after reset and SHALL flip to the other master whenever a grant ends.
REQ-014 GNTN SHALL hold while mN_cyc_i=1; the cycle after mN_cyc_i=0 the FSM SHALL return to IDLE (one dead cycle minimum between grants).
REQ-015 In GNTN, s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o SHALL combinationally equal master N's inputs.
REQ-016 In IDLE, all s_* outputs SHALL be 0.
REQ-017 mN_ack_o SHALL equal s_ack_i & mN_stb_i only while in GNTN, else 0.
REQ-018 mN_dat_o SHALL equal s_dat_i while in GNTN, else 32'h0.
REQ-019 A non-granted master's stb SHALL be ignored; it waits with no ack and no err.
REQ-020 A master dropping cyc in the same cycle as s_ack_i SHALL still receive that ack; the FSM SHALL then go to IDLE.
REQ-021 grant_o SHALL be 2'b01 in GNT0, 2'b10 in GNT1 and 2'b00 in IDLE.

Reset
REQ-022 nRST=0 SHALL asynchronously force IDLE, pointer=0, timeout counter=0, all outputs 0, including mid-transaction.
REQ-023 After nRST rises, arbitration SHALL resume on the first clk edge.

Configuration
REQ-024 With WB_ASCON_ARB_TIMEOUT_EN defined, a counter SHALL increment each granted cycle with stb=1 and s_ack_i=0, and clear on ack or grant end.
REQ-025 With the macro defined, when the counter reaches TIMEOUT_CYCLES, mN_err_o SHALL pulse 1 cycle, s_cyc_o/s_stb_o SHALL drop, and the FSM SHALL enter IDLE with the pointer flipped.
REQ-026 Without WB_ASCON_ARB_TIMEOUT_EN, mN_err_o SHALL be tied 0, no counter SHALL exist and a grant SHALL never be revoked.

Structure
REQ-027 Package wb_ascon_arb_pkg SHALL hold the state enum, the master-index typedef and the wb_ASCON address constants (CNTRL 0x04, KEY 0x08-0x14, NONCE 0x18-0x24, AD 0x28-0x34, RAM 0x48-0x64).
REQ-028 The timeout counter SHALL be sub-module wb_arb_timer, instantiated only under the macro.

Verification
REQ-029 m0 write 0x08 data 0x0C0D0E0F, m1 idle -> grant_o=01 next cycle; slave sees adr 0x08, data 0x0C0D0E0F; m0_ack_o follows s_ack_i.
REQ-030 m0 and m1 raise cyc in the same cycle after reset (m0 write 0x18, m1 write 0x28) -> m0 served first; after m0 drops cyc, IDLE for 1 cycle, then grant_o=10.
REQ-031 m1 holds cyc through three writes 0x48/0x4C/0x50 while m0 requests -> m1 keeps the grant for all three; m0 sees no ack until granted.
REQ-032 m0 read 0x04 with s_dat_i=0x00007C35 -> m0_dat_o=0x00007C35 with ack; m1_dat_o=0.
REQ-033 nRST pulsed low during m1's granted write -> all outputs 0 immediately; pointer=0 afterwards.
REQ-034 With the macro defined, TIMEOUT_CYCLES=8 and the slave never acking -> m0_err_o pulses at the 8th stalled cycle, s_cyc_o drops, a pending m1 is granted after IDLE.

Source files
------------

// File: rtl/wb_ascon_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the
// wb_ASCON slave: FSM state encodings, master index type and slave register map.
package wb_ascon_arb_pkg;

  // Arbiter FSM state type and its encodings
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_GNT0 = 2'd1;
  localparam arb_state_t ST_GNT1 = 2'd2;

  // Master index, also used as the round-robin pointer
  typedef logic master_idx_t;
  localparam master_idx_t MASTER0 = 1'b0;
  localparam master_idx_t MASTER1 = 1'b1;

  // wb_ASCON register map (byte addresses)
  localparam logic [31:0] ASCON_CNTRL       = 32'h0000_0004;
  localparam logic [31:0] ASCON_KEY_FIRST   = 32'h0000_0008;
  localparam logic [31:0] ASCON_KEY_LAST    = 32'h0000_0014;
  localparam logic [31:0] ASCON_NONCE_FIRST = 32'h0000_0018;
  localparam logic [31:0] ASCON_NONCE_LAST  = 32'h0000_0024;
  localparam logic [31:0] ASCON_AD_FIRST    = 32'h0000_0028;
  localparam logic [31:0] ASCON_AD_LAST     = 32'h0000_0034;
  localparam logic [31:0] ASCON_RAM_FIRST   = 32'h0000_0048;
  localparam logic [31:0] ASCON_RAM_LAST    = 32'h0000_0064;

  // True when the address hits a defined wb_ASCON register
  function automatic logic is_ascon_reg(input logic [31:0] adr);
    return (adr == ASCON_CNTRL) ||
           ((adr >= ASCON_KEY_FIRST)   && (adr <= ASCON_KEY_LAST))   ||
           ((adr >= ASCON_NONCE_FIRST) && (adr <= ASCON_NONCE_LAST)) ||
           ((adr >= ASCON_AD_FIRST)    && (adr <= ASCON_AD_LAST))    ||
           ((adr >= ASCON_RAM_FIRST)   && (adr <= ASCON_RAM_LAST));
  endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Stall counter for the arbiter: counts granted cycles with a strobe but no
// ack and flags the cycle in which the LIMIT-th such stall occurs.
module wb_arb_timer
  import wb_ascon_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] count_r;

  // The current stall is the LIMIT-th one when LIMIT-1 stalls are already counted
  assign hit = inc && (count_r == CW'(LIMIT - 1));

  // Stall counter: restart on ack, on grant end and once the limit fires
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count_r <= {CW{1'b0}};
    end else if (clr || hit) begin
      count_r <= {CW{1'b0}};
    end else if (inc) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/wb_ascon_arbiter.sv
// Two-master round-robin Wishbone arbiter driving a single wb_ASCON slave.
// Optional stalled-transfer timeout is enabled with `define WB_ASCON_ARB_TIMEOUT_EN;
// without it a grant lasts until the owning master drops cyc.
module wb_ascon_arbiter
  import wb_ascon_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);

  arb_state_t  state_r;
  arb_state_t  state_nxt_s;
  master_idx_t ptr_r;
  master_idx_t ptr_nxt_s;
  logic        timeout_s;

`ifdef WB_ASCON_ARB_TIMEOUT_EN
  logic granted_s;
  logic owner_stb_s;
  logic stall_s;

  // Stall qualification for the timeout counter
  always_comb begin
    granted_s   = (state_r == ST_GNT0) || (state_r == ST_GNT1);
    owner_stb_s = (state_r == ST_GNT1) ? m1_stb_i : m0_stb_i;
    stall_s     = granted_s && owner_stb_s && !s_ack_i;
  end

  wb_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .nRST (nRST),
    .clr  (!granted_s || s_ack_i),
    .inc  (stall_s),
    .hit  (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and round-robin pointer logic
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt_s = (ptr_r == MASTER0) ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_nxt_s = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_nxt_s = ST_GNT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i || timeout_s) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = ~ptr_r;
        end else begin
          state_nxt_s = ST_GNT0;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i || timeout_s) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = ~ptr_r;
        end else begin
          state_nxt_s = ST_GNT1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = ptr_r;
      end
    endcase
  end

  // FSM state and pointer registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
      ptr_r   <= MASTER0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Bus steering: the granted master sees the slave, everything else reads 0
  always_comb begin
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    s_sel_o  = 4'h0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = 32'h0;
    grant_o  = 2'b00;
    case (state_r)
      ST_GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = timeout_s;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = timeout_s;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_ascon_arbiter.sv
// Directed self-checking bench for wb_ascon_arbiter.
module tb_wb_ascon_arbiter;

`ifdef WB_ASCON_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        clk;
  logic        nRST;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r, m1_adr, m1_dat_w, m1_dat_r;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic        s_we, s_cyc, s_stb, s_ack;
  logic [1:0]  grant;

  int tests;
  int fails;

  wb_ascon_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .nRST(nRST),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_w), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_dat_o(m0_dat_r),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_w), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_dat_o(m1_dat_r),
    .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack), .s_dat_i(s_dat_r),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    clk = 1'b0; nRST = 1'b0;
    m0_adr = 32'h0; m0_dat_w = 32'h0; m0_sel = 4'h0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = 32'h0; m1_dat_w = 32'h0; m1_sel = 4'h0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack = 1'b0; s_dat_r = 32'h0;

    // Reset state
    #2;
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_s_cyc", {31'h0, s_cyc}, 32'h0);
    chk("rst_m0_err", {31'h0, m0_err}, 32'h0);
    #10 nRST = 1'b1;
    tick();
    chk("idle_grant", {30'h0, grant}, 32'h0);

    // Simultaneous requests after reset: m0 first, dead cycle, then m1
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF; m0_adr = 32'h18; m0_dat_w = 32'h1111_1111;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF; m1_adr = 32'h28; m1_dat_w = 32'h2222_2222;
    #1 chk("both_lat_grant", {30'h0, grant}, 32'h0);
    tick();
    chk("both_grant0", {30'h0, grant}, 32'h1);
    chk("both_s_adr0", s_adr, 32'h18);
    chk("both_s_dat0", s_dat_w, 32'h1111_1111);
    s_ack = 1'b1;
    #1;
    chk("both_m0_ack", {31'h0, m0_ack}, 32'h1);
    chk("both_m1_noack", {31'h0, m1_ack}, 32'h0);
    chk("both_m1_noerr", {31'h0, m1_err}, 32'h0);
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    tick();
    chk("both_dead_grant", {30'h0, grant}, 32'h0);
    chk("both_dead_s_cyc", {31'h0, s_cyc}, 32'h0);
    tick();
    chk("both_grant1", {30'h0, grant}, 32'h2);
    chk("both_s_adr1", s_adr, 32'h28);
    chk("both_s_dat1", s_dat_w, 32'h2222_2222);
    s_ack = 1'b1;
    #1;
    chk("both_m1_ack", {31'h0, m1_ack}, 32'h1);
    chk("both_m0_noack", {31'h0, m0_ack}, 32'h0);
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    tick();
    chk("both_end_grant", {30'h0, grant}, 32'h0);

    // Single m0 write to KEY0, ack in the same cycle cyc drops
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h08; m0_dat_w = 32'h0C0D_0E0F;
    #1 chk("w0_lat_grant", {30'h0, grant}, 32'h0);
    tick();
    chk("w0_grant", {30'h0, grant}, 32'h1);
    chk("w0_s_adr", s_adr, 32'h08);
    chk("w0_s_dat", s_dat_w, 32'h0C0D_0E0F);
    chk("w0_s_we", {31'h0, s_we}, 32'h1);
    chk("w0_ack_low", {31'h0, m0_ack}, 32'h0);
    s_ack = 1'b1;
    #1 chk("w0_ack_follow", {31'h0, m0_ack}, 32'h1);
    m0_cyc = 1'b0;
    #1 chk("w0_ack_on_drop", {31'h0, m0_ack}, 32'h1);
    tick();
    chk("w0_end_grant", {30'h0, grant}, 32'h0);
    chk("w0_idle_ack", {31'h0, m0_ack}, 32'h0);
    m0_stb = 1'b0; s_ack = 1'b0;

    // m1 holds the grant through three RAM writes while m0 waits
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0C; m0_dat_w = 32'h0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_adr = 32'h48; m1_dat_w = 32'hAAAA_0000;
    tick();
    chk("burst_grant", {30'h0, grant}, 32'h2);
    for (int k = 0; k < 3; k++) begin
      m1_adr = 32'h48 + 32'(4 * k);
      m1_dat_w = 32'hAAAA_0000 + 32'(k);
      s_ack = 1'b1;
      #1;
      chk("burst_s_adr", s_adr, 32'h48 + 32'(4 * k));
      chk("burst_hold", {30'h0, grant}, 32'h2);
      chk("burst_m1_ack", {31'h0, m1_ack}, 32'h1);
      chk("burst_m0_wait", {30'h0, m0_ack, m0_err}, 32'h0);
      tick();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    tick();
    chk("burst_dead", {30'h0, grant}, 32'h0);
    tick();
    chk("burst_m0_grant", {30'h0, grant}, 32'h1);
    chk("burst_m0_adr", s_adr, 32'h0C);

    // m0 read of CNTRL
    m0_we = 1'b0; m0_adr = 32'h04; s_dat_r = 32'h0000_7C35; s_ack = 1'b1;
    #1;
    chk("rd_m0_dat", m0_dat_r, 32'h0000_7C35);
    chk("rd_m0_ack", {31'h0, m0_ack}, 32'h1);
    chk("rd_m1_dat", m1_dat_r, 32'h0);
    chk("rd_s_we", {31'h0, s_we}, 32'h0);
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    tick();
    chk("rd_idle_dat", m0_dat_r, 32'h0);

    // Reset in the middle of m1's write, pointer back to m0
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h2C; m1_dat_w = 32'h5555_AAAA;
    tick();
    chk("rst_mid_grant1", {30'h0, grant}, 32'h2);
    s_ack = 1'b1;
    #1 chk("rst_mid_ack", {31'h0, m1_ack}, 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_grant", {30'h0, grant}, 32'h0);
    chk("rst_mid_s_cyc", {31'h0, s_cyc}, 32'h0);
    chk("rst_mid_s_adr", s_adr, 32'h0);
    chk("rst_mid_m1_ack", {31'h0, m1_ack}, 32'h0);
    chk("rst_mid_m1_dat", m1_dat_r, 32'h0);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h30; s_ack = 1'b0;
    #3 nRST = 1'b1;
    tick();
    chk("rst_ptr_grant0", {30'h0, grant}, 32'h1);

`ifdef WB_ASCON_ARB_TIMEOUT_EN
    // Stalled m0 transfer is revoked on the 8th stalled cycle, m1 then served
    for (int i = 1; i < 8; i++) begin
      chk("to_no_err", {31'h0, m0_err}, 32'h0);
      tick();
    end
    chk("to_m0_err", {31'h0, m0_err}, 32'h1);
    chk("to_m1_noerr", {31'h0, m1_err}, 32'h0);
    tick();
    chk("to_idle_grant", {30'h0, grant}, 32'h0);
    chk("to_s_cyc_drop", {31'h0, s_cyc}, 32'h0);
    chk("to_err_pulse", {31'h0, m0_err}, 32'h0);
    tick();
    chk("to_m1_grant", {30'h0, grant}, 32'h2);
`else
    // Without the timeout a stalled grant is never revoked
    repeat (300) tick();
    chk("nto_m0_err", {31'h0, m0_err}, 32'h0);
    chk("nto_grant", {30'h0, grant}, 32'h1);
    chk("nto_s_cyc", {31'h0, s_cyc}, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
